// File: rtl/tac_signed_array.sv
`default_nettype none
// ============================================================================
//  Module      : tac_signed_array
//  Description : Multi-channel signed temporal accumulator. N_CH channels
//                share one spike line (tac_in) and one input sign (sign_x).
//                Each channel adds +/- its own weight on every spike cycle
//                inside a window of win_len cycles. The result is offered
//                through a valid/ready handshake. On overflow the channel
//                either saturates or wraps, depending on SAT_EN.
//
//  Ports       : clk, rst          clock / synchronous active-high reset
//                start, win_len    open a window of win_len accumulate cycles
//                tac_in, sign_x    shared spike and input sign
//                tac_w, sign_w     per-channel weight magnitude and sign
//                out_ready         downstream accepts the result
//                busy, out_valid   ACCUM / DONE indicators
//                tac_lsb, tac_msb  per-channel split accumulator
//                ovf               sticky per-channel overflow flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tac_signed_array #(
   parameter int N_CH     = 4,
   parameter int W_BITS   = 8,
   parameter int LSB_BITS = 12,
   parameter int MSB_BITS = 6,
   parameter int WIN_BITS = 8,
   parameter int SAT_EN   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIN_BITS-1:0]        win_len,
   input  logic                       tac_in,
   input  logic                       sign_x,
   input  logic [N_CH*W_BITS-1:0]     tac_w,
   input  logic [N_CH-1:0]            sign_w,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       out_valid,
   output logic [N_CH*LSB_BITS-1:0]   tac_lsb,
   output logic [N_CH*MSB_BITS-1:0]   tac_msb,
   output logic [N_CH-1:0]            ovf
);

   // Full accumulator width; MSB and LSB fields are simply the upper and
   // lower parts of one two's-complement value, so carry/borrow between
   // them falls out of a single full-width add.
   localparam int c_TOT = MSB_BITS + LSB_BITS;
   // Working width: wide enough that neither the sign-extended value nor
   // the negated weight can overflow before the range check.
   localparam int c_EXT = ((c_TOT > W_BITS) ? c_TOT : W_BITS) + 2;

   localparam logic signed [c_EXT-1:0] c_MAX =
      {{(c_EXT-c_TOT+1){1'b0}}, {(c_TOT-1){1'b1}}};
   localparam logic signed [c_EXT-1:0] c_MIN =
      {{(c_EXT-c_TOT+1){1'b1}}, {(c_TOT-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIN_BITS-1:0] r_cnt;
   logic [WIN_BITS-1:0] w_cnt_nxt;
   logic                w_clear;
   logic                w_acc_en;

   // ------------------------------------------------------------------------
   // Window state machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear     = 1'b1;
               w_cnt_nxt   = win_len;
               w_state_nxt = (win_len == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            // The edge that takes the counter from 1 to 0 carries the
            // final accumulate, so ACCUM spans exactly win_len cycles.
            w_cnt_nxt = r_cnt - WIN_BITS'(1);
            if (r_cnt <= WIN_BITS'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // start without out_ready is ignored so the result is not lost.
            if (out_ready) begin
               if (start) begin
                  w_clear     = 1'b1;
                  w_cnt_nxt   = win_len;
                  w_state_nxt = (win_len == '0) ? S_DONE : S_ACCUM;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_acc_en  = (r_state == S_ACCUM) && tac_in;
   assign busy      = (r_state == S_ACCUM);
   assign out_valid = (r_state == S_DONE);

   // ------------------------------------------------------------------------
   // Per-channel accumulators
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [c_TOT-1:0]        r_acc;
      logic                    r_ovf;
      logic [W_BITS-1:0]       w_w;
      logic signed [c_EXT-1:0] w_v;
      logic signed [c_EXT-1:0] w_mag;
      logic signed [c_EXT-1:0] w_step;
      logic signed [c_EXT-1:0] w_sum;
      logic                    w_hi;
      logic                    w_lo;
      logic [c_TOT-1:0]        w_res;

      assign w_w    = tac_w[i*W_BITS +: W_BITS];
      assign w_v    = {{(c_EXT-c_TOT){r_acc[c_TOT-1]}}, r_acc};
      assign w_mag  = {{(c_EXT-W_BITS){1'b0}}, w_w};
      // Equal signs (XNOR) give a positive step.
      assign w_step = (sign_x == sign_w[i]) ? w_mag : -w_mag;
      assign w_sum  = w_v + w_step;
      assign w_hi   = (w_sum > c_MAX);
      assign w_lo   = (w_sum < c_MIN);

      // Without saturation the low c_TOT bits are the wrapped result.
      always_comb begin
         w_res = w_sum[c_TOT-1:0];
         if (SAT_EN != 0) begin
            if (w_hi) begin
               w_res = c_MAX[c_TOT-1:0];
            end else if (w_lo) begin
               w_res = c_MIN[c_TOT-1:0];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_acc_en) begin
            r_acc <= w_res;
            if (w_hi || w_lo) begin
               r_ovf <= 1'b1;
            end
         end
      end

      assign tac_lsb[i*LSB_BITS +: LSB_BITS] = r_acc[LSB_BITS-1:0];
      assign tac_msb[i*MSB_BITS +: MSB_BITS] = r_acc[c_TOT-1:LSB_BITS];
      assign ovf[i]                          = r_ovf;
   end

endmodule
`default_nettype wire
